// File: rtl/fsm_3b.sv
// Pop/valid control between a non-show-ahead raw-data FIFO and its consumer.
// Keeps at most one popped word outstanding and refills on acceptance.
module fsm_3b (
  input  logic clk,
  input  logic reset,
  input  logic raw_data_out_fifo_empty,
  input  logic raw_data_accepted,
  output logic raw_data_out_pop,
  output logic raw_data_valid
);

  typedef enum logic [1:0] {
    StInit    = 2'b00,
    StVFetch  = 2'b01,
    StVReady  = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit: state_d = StVFetch;
      StVFetch: begin
        if (!raw_data_out_fifo_empty) state_d = StVReady;
      end
      StVReady: begin
        // Back-to-back acceptance stays here; only a drained FIFO falls back to fetch.
        if (raw_data_accepted && raw_data_out_fifo_empty) state_d = StVFetch;
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    raw_data_out_pop = 1'b0;
    raw_data_valid   = 1'b0;
    if (!reset) begin
      case (state_q)
        StVFetch: raw_data_out_pop = !raw_data_out_fifo_empty;
        StVReady: begin
          raw_data_valid   = 1'b1;
          raw_data_out_pop = raw_data_accepted && !raw_data_out_fifo_empty;
        end
        default: begin
          raw_data_out_pop = 1'b0;
          raw_data_valid   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_3b.sv
// Directed and randomized checks of fsm_3b against a word-occupancy model.
module tb_fsm_3b;

  logic clk;
  logic reset;
  logic raw_data_out_fifo_empty;
  logic raw_data_accepted;
  logic raw_data_out_pop;
  logic raw_data_valid;

  int unsigned n_cmp;
  int unsigned n_fail;

  // Model: m_init = dead cycle after reset; m_hold = a popped word sits on FIFO q.
  bit m_init;
  bit m_hold;

  fsm_3b dut (
    .clk                     (clk),
    .reset                   (reset),
    .raw_data_out_fifo_empty (raw_data_out_fifo_empty),
    .raw_data_accepted       (raw_data_accepted),
    .raw_data_out_pop        (raw_data_out_pop),
    .raw_data_valid          (raw_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit r, input bit e, input bit a, input string tag);
    logic exp_pop;
    logic exp_valid;
    raw_data_out_fifo_empty = e;
    raw_data_accepted       = a;
    reset                   = r;
    #2;
    exp_valid = !r && !m_init && m_hold;
    exp_pop   = !r && !m_init && !e && (!m_hold || a);
    n_cmp++;
    assert (raw_data_valid === exp_valid) else begin
      n_fail++;
      $error("FAIL %s valid: got %b want %b", tag, raw_data_valid, exp_valid);
    end
    n_cmp++;
    assert (raw_data_out_pop === exp_pop) else begin
      n_fail++;
      $error("FAIL %s pop: got %b want %b", tag, raw_data_out_pop, exp_pop);
    end
    n_cmp++;
    assert ((raw_data_out_pop && e) !== 1'b1) else begin
      n_fail++;
      $error("FAIL %s pop_while_empty: got pop=%b empty=%b want pop=0", tag,
             raw_data_out_pop, e);
    end
    @(posedge clk);
    if (r) begin
      m_init = 1'b1;
      m_hold = 1'b0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else begin
      m_hold = exp_pop || (m_hold && !a);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_init = 1'b1;
    m_hold = 1'b0;
    reset = 1'b1;
    raw_data_out_fifo_empty = 1'b1;
    raw_data_accepted = 1'b0;
    @(negedge clk);

    // Reset, INIT, then idle fetch while empty.
    step(1, 1, 0, "reset0");
    step(1, 1, 0, "reset1");
    step(0, 1, 0, "init");
    step(0, 1, 0, "fetch_empty0");
    step(0, 1, 1, "fetch_empty_acc");
    // Fetch, then streaming acceptance.
    step(0, 0, 0, "fetch_pop");
    for (int i = 0; i < 4; i++) step(0, 0, 1, "stream");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "hold");
    step(0, 1, 0, "hold_empty");
    step(0, 1, 1, "accept_drain");
    step(0, 1, 0, "refetch_empty");
    step(0, 0, 0, "refetch_pop");
    step(0, 0, 0, "refetch_valid");
    // Reset mid-stream discards the word and restarts.
    step(1, 0, 1, "midreset");
    step(0, 0, 1, "restart_init");
    step(0, 0, 0, "restart_fetch");
    step(0, 0, 1, "restart_ready");

    for (int i = 0; i < 400; i++) begin
      bit r, e, a;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, 1) == 1;
      step(r, e, a, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
